aip_mux_rr_arbiter: RTL and testbench

//   Packet-aware round-robin arbiter and sequencer for the AIP parametric data mux.
//   It shares one DATAWIDTH output channel between 2**SELBITS valid/ready requesters.
//   It drives the mux select internally and registers the selected beat into a
//   one-deep output stage.
//   It sits between the interpolator input lanes and the single downstream datapath consumer.

---
 rtl/aip_mux_rr_arbiter_if.sv | 28 ++
 rtl/aip_mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_aip_mux_rr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aip_mux_rr_arbiter_if.sv
// Valid/ready bundle between the requester lanes, the arbiter and the downstream consumer.
// The arbiter attaches through the slave modport; the driving environment uses master.
interface aip_mux_rr_arbiter_if #(
  parameter int DATAWIDTH = 32,
  parameter int SELBITS   = 2
);
  localparam int N = 1 << SELBITS;

  logic [N-1:0]           in_valid;
  logic [N-1:0]           in_last;
  logic [N*DATAWIDTH-1:0] in_data;
  logic [N-1:0]           in_ready;
  logic                   out_valid;
  logic [DATAWIDTH-1:0]   out_data;
  logic                   out_last;
  logic [SELBITS-1:0]     out_sel;
  logic                   out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/aip_mux_rr_arbiter.sv
// Packet-aware round-robin arbiter: grants one of N requesters, holds the grant for a
// whole packet, and registers the selected beat into a one-deep output stage.
module aip_mux_rr_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int SELBITS   = 2
) (
  input  logic                clk,
  input  logic                rst_a,
  input  logic                clr_s,
  aip_mux_rr_arbiter_if.slave bus,
  output logic                busy
);
  localparam int N = 1 << SELBITS;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state,     state_nxt;
  logic [SELBITS-1:0]   rr_ptr,    rr_ptr_nxt;
  logic [SELBITS-1:0]   lock_id,   lock_id_nxt;
  logic                 out_valid, out_valid_nxt;
  logic [DATAWIDTH-1:0] out_data,  out_data_nxt;
  logic                 out_last,  out_last_nxt;
  logic [SELBITS-1:0]   out_sel,   out_sel_nxt;

  logic                 grant_hit;
  logic [SELBITS-1:0]   grant_id;
  logic                 slot_free;
  logic                 accept;

  // NOTE: every comb output gets a default before any branch so no latch is inferred.
  always_comb begin : grant_select
    logic [SELBITS-1:0] idx;
    grant_hit = 1'b0;
    grant_id  = '0;
    idx       = '0;
    if (state == LOCKED) begin
      grant_id  = lock_id;
      grant_hit = bus.in_valid[lock_id];
    end else begin
      // Index arithmetic wraps naturally because N is a power of two.
      for (int k = 0; k < N; k++) begin
        idx = rr_ptr + SELBITS'(k);
        if (!grant_hit && bus.in_valid[idx]) begin
          grant_hit = 1'b1;
          grant_id  = idx;
        end
      end
    end
  end

  // No requester may see an accept while either reset is discarding the capture.
  assign slot_free    = !out_valid || bus.out_ready;
  assign accept       = grant_hit && slot_free && rst_a && !clr_s;
  assign bus.in_ready = accept ? ({{(N-1){1'b0}}, 1'b1} << grant_id) : '0;

  always_comb begin : next_state
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    lock_id_nxt   = lock_id;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    out_sel_nxt   = out_sel;
    if (clr_s) begin
      state_nxt     = IDLE;
      rr_ptr_nxt    = '0;
      lock_id_nxt   = '0;
      out_valid_nxt = 1'b0;
      out_data_nxt  = '0;
      out_last_nxt  = 1'b0;
      out_sel_nxt   = '0;
    end else if (accept) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = bus.in_data[DATAWIDTH*grant_id +: DATAWIDTH];
      out_last_nxt  = bus.in_last[grant_id];
      out_sel_nxt   = grant_id;
      if (bus.in_last[grant_id]) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = grant_id + SELBITS'(1);
      end else begin
        state_nxt   = LOCKED;
        lock_id_nxt = grant_id;
      end
    end else if (out_valid && bus.out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lock_id   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      lock_id   <= lock_id_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      out_sel   <= out_sel_nxt;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.out_sel   = out_sel;
  assign busy          = (state == LOCKED);
endmodule

// File: tb/tb_aip_mux_rr_arbiter.sv
// Directed bench for aip_mux_rr_arbiter (DATAWIDTH=8, SELBITS=2): rotation, packet lock,
// backpressure, bubbles inside a lock, and async/sync reset in the middle of a packet.
module tb_aip_mux_rr_arbiter;
  localparam int DW = 8;
  localparam int SB = 2;

  logic clk;
  logic rst_a;
  logic clr_s;
  logic busy;

  int tests_run    = 0;
  int tests_failed = 0;

  aip_mux_rr_arbiter_if #(.DATAWIDTH(DW), .SELBITS(SB)) bus ();

  aip_mux_rr_arbiter #(.DATAWIDTH(DW), .SELBITS(SB)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .clr_s (clr_s),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] valid, input logic [3:0] last, input logic ready);
    bus.in_valid  = valid;
    bus.in_last   = last;
    bus.out_ready = ready;
  endtask

  task automatic set_lanes(input logic [7:0] d3, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic test_reset;
    rst_a = 1'b0;
    clr_s = 1'b0;
    set_lanes(8'h43, 8'h32, 8'h21, 8'h10);
    drive(4'hF, 4'hF, 1'b1);
    #1;
    if (bus.in_ready !== 4'h0) begin
      $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); tests_failed++;
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); tests_failed++;
    end
    tests_run++;
    if (bus.out_sel !== 2'd0) begin
      $display("FAIL reset_out_sel: got %0d want 0", bus.out_sel); tests_failed++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy: got %b want 0", busy); tests_failed++;
    end
    tests_run++;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_rotation;
    logic [7:0] lane_val [4];
    logic [3:0] exp_rdy;
    lane_val = '{8'h10, 8'h21, 8'h32, 8'h43};
    drive(4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      #1;
      if (bus.in_ready !== exp_rdy) begin
        $display("FAIL rot_in_ready[%0d]: got %b want %b", i, bus.in_ready, exp_rdy); tests_failed++;
      end
      tests_run++;
      @(posedge clk); #1;
      if (bus.out_sel !== 2'(i % 4) || bus.out_valid !== 1'b1) begin
        $display("FAIL rot_out_sel[%0d]: got sel=%0d valid=%b want sel=%0d valid=1",
                 i, bus.out_sel, bus.out_valid, i % 4); tests_failed++;
      end
      tests_run++;
      if (bus.out_data !== lane_val[i % 4]) begin
        $display("FAIL rot_out_data[%0d]: got %h want %h", i, bus.out_data, lane_val[i % 4]); tests_failed++;
      end
      tests_run++;
      @(negedge clk);
    end
  endtask

  task automatic test_packet_lock;
    logic [3:0] v_tab [4];
    logic [3:0] l_tab [4];
    logic [3:0] r_tab [4];
    logic [1:0] s_tab [4];
    logic       b_tab [4];
    v_tab = '{4'b0010, 4'b1111, 4'b1111, 4'b1111};
    l_tab = '{4'b0000, 4'b1101, 4'b1111, 4'b1111};
    r_tab = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    s_tab = '{2'd1, 2'd1, 2'd1, 2'd2};
    b_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(v_tab[i], l_tab[i], 1'b1);
      #1;
      if (bus.in_ready !== r_tab[i]) begin
        $display("FAIL lock_in_ready[%0d]: got %b want %b", i, bus.in_ready, r_tab[i]); tests_failed++;
      end
      tests_run++;
      @(posedge clk); #1;
      if (bus.out_sel !== s_tab[i] || busy !== b_tab[i]) begin
        $display("FAIL lock_sel_busy[%0d]: got sel=%0d busy=%b want sel=%0d busy=%b",
                 i, bus.out_sel, busy, s_tab[i], b_tab[i]); tests_failed++;
      end
      tests_run++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    set_lanes(8'hA5, 8'h32, 8'h21, 8'h10);
    drive(4'b1000, 4'hF, 1'b1);
    #1;
    if (bus.in_ready !== 4'b1000) begin
      $display("FAIL bp_load_ready: got %b want 1000", bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(posedge clk); #1;
    if (bus.out_data !== 8'hA5 || bus.out_sel !== 2'd3) begin
      $display("FAIL bp_load: got data=%h sel=%0d want data=a5 sel=3", bus.out_data, bus.out_sel); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
    drive(4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.in_ready !== 4'h0) begin
        $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, bus.in_ready); tests_failed++;
      end
      tests_run++;
      @(posedge clk); #1;
      if (bus.out_data !== 8'hA5 || bus.out_valid !== 1'b1) begin
        $display("FAIL bp_hold[%0d]: got data=%h valid=%b want data=a5 valid=1",
                 i, bus.out_data, bus.out_valid); tests_failed++;
      end
      tests_run++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    if (bus.in_ready !== 4'b0001) begin
      $display("FAIL bp_release_ready: got %b want 0001", bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(posedge clk); #1;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || bus.out_sel !== 2'd0) begin
      $display("FAIL bp_drain_capture: got valid=%b data=%h sel=%0d want valid=1 data=10 sel=0",
               bus.out_valid, bus.out_data, bus.out_sel); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
  endtask

  task automatic test_bubble_lock;
    drive(4'b1000, 4'b0000, 1'b1);
    #1;
    if (bus.in_ready !== 4'b1000) begin
      $display("FAIL bub_first_ready: got %b want 1000", bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(posedge clk); #1;
    if (bus.out_sel !== 2'd3 || busy !== 1'b1 || bus.out_last !== 1'b0) begin
      $display("FAIL bub_first: got sel=%0d busy=%b last=%b want sel=3 busy=1 last=0",
               bus.out_sel, busy, bus.out_last); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
    drive(4'b0001, 4'hF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus.in_ready !== 4'h0) begin
        $display("FAIL bub_in_ready[%0d]: got %b want 0000", i, bus.in_ready); tests_failed++;
      end
      tests_run++;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL bub_state[%0d]: got valid=%b busy=%b want valid=0 busy=1",
                 i, bus.out_valid, busy); tests_failed++;
      end
      tests_run++;
      @(negedge clk);
    end
    drive(4'b1001, 4'hF, 1'b1);
    #1;
    if (bus.in_ready !== 4'b1000) begin
      $display("FAIL bub_resume_ready: got %b want 1000", bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(posedge clk); #1;
    if (bus.out_sel !== 2'd3 || bus.out_valid !== 1'b1 || busy !== 1'b0 || bus.out_last !== 1'b1) begin
      $display("FAIL bub_resume: got sel=%0d valid=%b busy=%b last=%b want sel=3 valid=1 busy=0 last=1",
               bus.out_sel, bus.out_valid, busy, bus.out_last); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet;
    drive(4'b0100, 4'b0000, 1'b1);
    #1;
    if (bus.in_ready !== 4'b0100) begin
      $display("FAIL rmp_lock_ready: got %b want 0100", bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(posedge clk); #1;
    if (busy !== 1'b1 || bus.out_sel !== 2'd2) begin
      $display("FAIL rmp_locked: got busy=%b sel=%0d want busy=1 sel=2", busy, bus.out_sel); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
    rst_a = 1'b0;
    drive(4'hF, 4'hF, 1'b1);
    #1;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 4'h0) begin
      $display("FAIL rmp_async: got busy=%b valid=%b ready=%b want busy=0 valid=0 ready=0000",
               busy, bus.out_valid, bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    if (bus.in_ready !== 4'b0001) begin
      $display("FAIL rmp_restart_ready: got %b want 0001", bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(posedge clk); #1;
    if (bus.out_sel !== 2'd0 || busy !== 1'b0 || bus.out_data !== 8'h10) begin
      $display("FAIL rmp_restart: got sel=%0d busy=%b data=%h want sel=0 busy=0 data=10",
               bus.out_sel, busy, bus.out_data); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
  endtask

  task automatic test_sync_clear;
    drive(4'b0010, 4'b0000, 1'b1);
    @(posedge clk); #1;
    if (busy !== 1'b1 || bus.out_sel !== 2'd1) begin
      $display("FAIL clr_locked: got busy=%b sel=%0d want busy=1 sel=1", busy, bus.out_sel); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
    clr_s = 1'b1;
    drive(4'hF, 4'hF, 1'b1);
    #1;
    if (bus.in_ready !== 4'h0) begin
      $display("FAIL clr_in_ready: got %b want 0000", bus.in_ready); tests_failed++;
    end
    tests_run++;
    @(posedge clk); #1;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h00) begin
      $display("FAIL clr_state: got valid=%b busy=%b sel=%0d data=%h want valid=0 busy=0 sel=0 data=00",
               bus.out_valid, busy, bus.out_sel, bus.out_data); tests_failed++;
    end
    tests_run++;
    @(negedge clk);
    clr_s = 1'b0;
    #1;
    if (bus.in_ready !== 4'b0001) begin
      $display("FAIL clr_restart_ready: got %b want 0001", bus.in_ready); tests_failed++;
    end
    tests_run++;
  endtask

  initial begin
    test_reset;
    test_rotation;
    test_packet_lock;
    test_backpressure;
    test_bubble_lock;
    test_reset_mid_packet;
    test_sync_clear;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
